// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU sequencer.
// Data width comes from the project-wide B_WIDTH macro.
`ifndef B_WIDTH
`define B_WIDTH 16
`endif

package alu_seq_pkg;

  localparam int BW = `B_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_DEC  = 4'd6;
  localparam logic [3:0] OP_INC  = 4'd7;
  localparam logic [3:0] OP_ADD2 = 4'd8;
  localparam logic [3:0] OP_SUB2 = 4'd9;
  localparam logic [3:0] OP_AND2 = 4'd10;
  localparam logic [3:0] OP_OR2  = 4'd11;
  localparam logic [3:0] OP_XOR2 = 4'd12;
  localparam logic [3:0] OP_NOT2 = 4'd13;
  localparam logic [3:0] OP_DEC2 = 4'd14;
  localparam logic [3:0] OP_INC2 = 4'd15;

  localparam int DOUBLE_BIT = 3;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;

endpackage

// File: rtl/alu_regfile.sv
// Register file: two pair-read ports, one debug read port,
// writeback and load write ports (writeback wins on collision).
module alu_regfile
  import alu_seq_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ra_addr,
  output logic [BW-1:0] ra_lo,
  output logic [BW-1:0] ra_hi,
  input  logic [AW-1:0] rb_addr,
  output logic [BW-1:0] rb_lo,
  output logic [BW-1:0] rb_hi,
  input  logic [AW-1:0] rd_addr,
  output logic [BW-1:0] rd_data,
  input  logic          wb_en,
  input  logic          wb_pair,
  input  logic [AW-1:0] wb_addr,
  input  logic [BW-1:0] wb_lo,
  input  logic [BW-1:0] wb_hi,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [BW-1:0] ld_data
);

  logic [BW-1:0] regs_q [NUM_REGS];
  logic [BW-1:0] regs_d [NUM_REGS];

  logic [AW-1:0] ra_odd;
  logic [AW-1:0] rb_odd;
  logic [AW-1:0] wb_even;
  logic [AW-1:0] wb_odd;

  assign ra_odd  = {ra_addr[AW-1:1], 1'b1};
  assign rb_odd  = {rb_addr[AW-1:1], 1'b1};
  assign wb_even = {wb_addr[AW-1:1], 1'b0};
  assign wb_odd  = {wb_addr[AW-1:1], 1'b1};

  assign ra_lo   = regs_q[ra_addr];
  assign ra_hi   = regs_q[ra_odd];
  assign rb_lo   = regs_q[rb_addr];
  assign rb_hi   = regs_q[rb_odd];
  assign rd_data = regs_q[rd_addr];

  // Load applied first so a same-register writeback overrides it.
  always_comb begin
    regs_d = regs_q;
    if (ld_en) begin
      regs_d[ld_addr] = ld_data;
    end
    if (wb_en) begin
      if (wb_pair) begin
        regs_d[wb_even] = wb_lo;
        regs_d[wb_odd]  = wb_hi;
      end else begin
        regs_d[wb_addr] = wb_lo;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Command sequencer owning the ALU operand side: fetches
// operands, drives the ALU, writes back and returns a response.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [3:0]    cmd_op,
  input  logic [AW-1:0] cmd_dst,
  input  logic [AW-1:0] cmd_srca,
  input  logic [AW-1:0] cmd_srcb,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [BW-1:0] rsp_lo,
  output logic [BW-1:0] rsp_hi,
  output logic [2:0]    rsp_flags,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [BW-1:0] ld_data,
  input  logic [AW-1:0] rd_addr,
  output logic [BW-1:0] rd_data,
  output logic [2:0]    status,
  output logic [BW-1:0] alu_ha,
  output logic [BW-1:0] alu_la,
  output logic [BW-1:0] alu_hb,
  output logic [BW-1:0] alu_lb,
  output logic [3:0]    alu_op,
  input  logic [BW-1:0] alu_lc,
  input  logic [BW-1:0] alu_hc,
  input  logic          alu_zr,
  input  logic          alu_ng,
  input  logic          alu_carry
);

  state_e        state_q, state_d;
  logic [3:0]    op_q, op_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [BW-1:0] ha_q, ha_d;
  logic [BW-1:0] la_q, la_d;
  logic [BW-1:0] hb_q, hb_d;
  logic [BW-1:0] lb_q, lb_d;
  logic [BW-1:0] rsp_lo_q, rsp_lo_d;
  logic [BW-1:0] rsp_hi_q, rsp_hi_d;
  logic [2:0]    rsp_flags_q, rsp_flags_d;
  logic [2:0]    status_q, status_d;

  logic          cmd_dbl;
  logic          op_dbl;
  logic [AW-1:0] ra_addr;
  logic [AW-1:0] rb_addr;
  logic [BW-1:0] ra_lo, ra_hi;
  logic [BW-1:0] rb_lo, rb_hi;
  logic [2:0]    alu_flags;
  logic          wb_en;

  assign cmd_dbl = cmd_op[DOUBLE_BIT];
  assign op_dbl  = op_q[DOUBLE_BIT];

  // Pair operands are even-aligned; odd indices round down.
  assign ra_addr = cmd_dbl ? {cmd_srca[AW-1:1], 1'b0} : cmd_srca;
  assign rb_addr = cmd_dbl ? {cmd_srcb[AW-1:1], 1'b0} : cmd_srcb;

  always_comb begin
    alu_flags         = '0;
    alu_flags[FLAG_C] = alu_carry;
    alu_flags[FLAG_N] = alu_ng;
    alu_flags[FLAG_Z] = alu_zr;
  end

  assign wb_en = (state_q == EXEC);

  alu_regfile #(
    .NUM_REGS(NUM_REGS),
    .AW      (AW)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .ra_addr(ra_addr),
    .ra_lo  (ra_lo),
    .ra_hi  (ra_hi),
    .rb_addr(rb_addr),
    .rb_lo  (rb_lo),
    .rb_hi  (rb_hi),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .wb_en  (wb_en),
    .wb_pair(op_dbl),
    .wb_addr(dst_q),
    .wb_lo  (alu_lc),
    .wb_hi  (alu_hc),
    .ld_en  (ld_en),
    .ld_addr(ld_addr),
    .ld_data(ld_data)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    dst_d       = dst_q;
    ha_d        = ha_q;
    la_d        = la_q;
    hb_d        = hb_q;
    lb_d        = lb_q;
    rsp_lo_d    = rsp_lo_q;
    rsp_hi_d    = rsp_hi_q;
    rsp_flags_d = rsp_flags_q;
    status_d    = status_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          dst_d   = cmd_dst;
          la_d    = ra_lo;
          lb_d    = rb_lo;
          ha_d    = cmd_dbl ? ra_hi : '0;
          hb_d    = cmd_dbl ? rb_hi : '0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        rsp_lo_d    = alu_lc;
        rsp_hi_d    = op_dbl ? alu_hc : '0;
        rsp_flags_d = alu_flags;
        status_d    = alu_flags;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= '0;
      dst_q       <= '0;
      ha_q        <= '0;
      la_q        <= '0;
      hb_q        <= '0;
      lb_q        <= '0;
      rsp_lo_q    <= '0;
      rsp_hi_q    <= '0;
      rsp_flags_q <= '0;
      status_q    <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      dst_q       <= dst_d;
      ha_q        <= ha_d;
      la_q        <= la_d;
      hb_q        <= hb_d;
      lb_q        <= lb_d;
      rsp_lo_q    <= rsp_lo_d;
      rsp_hi_q    <= rsp_hi_d;
      rsp_flags_q <= rsp_flags_d;
      status_q    <= status_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_lo    = rsp_lo_q;
  assign rsp_hi    = rsp_hi_q;
  assign rsp_flags = rsp_flags_q;
  assign status    = status_q;
  assign alu_ha    = ha_q;
  assign alu_la    = la_q;
  assign alu_hb    = hb_q;
  assign alu_lb    = lb_q;
  assign alu_op    = op_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural ALU
// and a register-file reference model.
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  localparam int NR = 8;
  localparam int AW = 3;

  logic          clk = 0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_op;
  logic [AW-1:0] cmd_dst, cmd_srca, cmd_srcb;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [BW-1:0] rsp_lo, rsp_hi;
  logic [2:0]    rsp_flags;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [BW-1:0] ld_data;
  logic [AW-1:0] rd_addr;
  logic [BW-1:0] rd_data;
  logic [2:0]    status;
  logic [BW-1:0] alu_ha, alu_la, alu_hb, alu_lb;
  logic [3:0]    alu_op;
  logic [BW-1:0] alu_lc, alu_hc;
  logic          alu_zr, alu_ng, alu_carry;

  alu_sequencer #(.NUM_REGS(NR)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_dst(cmd_dst),
    .cmd_srca(cmd_srca), .cmd_srcb(cmd_srcb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_lo(rsp_lo), .rsp_hi(rsp_hi), .rsp_flags(rsp_flags),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .status(status),
    .alu_ha(alu_ha), .alu_la(alu_la),
    .alu_hb(alu_hb), .alu_lb(alu_lb), .alu_op(alu_op),
    .alu_lc(alu_lc), .alu_hc(alu_hc),
    .alu_zr(alu_zr), .alu_ng(alu_ng), .alu_carry(alu_carry)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errs = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] lo;
    logic [15:0] hi;
    logic [2:0]  fl;
    int          t;
  } exp_t;

  exp_t q[$];
  logic [15:0] m [NR];
  int rdy_mode = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Returns {carry, hi, lo} computed with plain arithmetic.
  function automatic logic [32:0] ref_alu(input logic [3:0] op,
                                          input logic [31:0] a_in,
                                          input logic [31:0] b_in);
    logic [32:0] r;
    logic [31:0] a, b;
    a = a_in;
    b = b_in;
    if (!op[3]) begin
      a[31:16] = '0;
      b[31:16] = '0;
    end
    case (op[2:0])
      3'd0: r = {1'b0, a} + {1'b0, b};
      3'd1: r = {1'b0, a} - {1'b0, b};
      3'd2: r = {1'b0, a & b};
      3'd3: r = {1'b0, a | b};
      3'd4: r = {1'b0, a ^ b};
      3'd5: r = {1'b0, ~a};
      3'd6: r = {1'b0, a - 32'd1};
      default: r = {1'b0, a + 32'd1};
    endcase
    if (op[3])
      return {(op == 4'd8) ? r[32] : 1'b0, r[31:0]};
    return {(op == 4'd0) ? r[16] : 1'b0, 16'h0, r[15:0]};
  endfunction

  // Behavioural ALU; its high word is junk for single ops.
  always_comb begin
    logic [32:0] r;
    r = ref_alu(alu_op, {alu_ha, alu_la}, {alu_hb, alu_lb});
    alu_carry = r[32];
    alu_lc    = r[15:0];
    alu_hc    = alu_op[3] ? r[31:16] : ~r[15:0];
    alu_zr    = (r[15:0] == 16'h0);
    alu_ng    = r[15];
  end

  initial begin
    rsp_ready = 0;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0: rsp_ready = 1'($urandom_range(0, 1));
        1: rsp_ready = 1;
        default: rsp_ready = 0;
      endcase
    end
  end

  // Monitor: compares every presented response with the queue head.
  initial begin
    bit seen = 0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        seen = 0;
      end else if (rsp_valid) begin
        if (q.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL unexpected_rsp: lo %h with empty queue", rsp_lo);
        end else begin
          if (!seen) begin
            chk("latency", cyc, q[0].t + 2);
            seen = 1;
          end
          chk("rsp_lo", rsp_lo, q[0].lo);
          chk("rsp_hi", rsp_hi, q[0].hi);
          chk("rsp_flags", rsp_flags, q[0].fl);
          chk("busy_cmd_ready", cmd_ready, 0);
          if (rsp_ready) begin
            chk("status", status, q[0].fl);
            void'(q.pop_front());
            seen = 0;
          end
        end
      end
    end
  end

  task automatic load(input int a, input logic [15:0] d);
    @(negedge clk);
    ld_en = 1;
    ld_addr = AW'(a);
    ld_data = d;
    @(posedge clk);
    m[a] = d;
    #1 ld_en = 0;
  endtask

  task automatic chk_reg(input string nm, input int a,
                         input logic [15:0] exp);
    @(negedge clk);
    rd_addr = AW'(a);
    #1 chk(nm, rd_data, exp);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic issue(input logic [3:0] op, input int dst,
                       input int sa, input int sb,
                       input bit l0, input int a0, input logic [15:0] d0,
                       input bit l1, input int a1, input logic [15:0] d1);
    exp_t e;
    logic [31:0] av, bv;
    logic [32:0] r;
    int pa, pb, pd;
    wait_idle();
    if (!cmd_ready) begin
      checks++;
      errs++;
      $display("FAIL accept_timeout: cmd_ready %b required 1", cmd_ready);
      return;
    end
    cmd_valid = 1;
    cmd_op = op;
    cmd_dst = AW'(dst);
    cmd_srca = AW'(sa);
    cmd_srcb = AW'(sb);
    ld_en = l0;
    ld_addr = AW'(a0);
    ld_data = d0;
    pa = sa - (sa % 2);
    pb = sb - (sb % 2);
    pd = dst - (dst % 2);
    av = op[3] ? {m[pa + 1], m[pa]} : {16'h0, m[sa]};
    bv = op[3] ? {m[pb + 1], m[pb]} : {16'h0, m[sb]};
    r = ref_alu(op, av, bv);
    e.lo = r[15:0];
    e.hi = op[3] ? r[31:16] : 16'h0;
    e.fl = {r[32], r[15], r[15:0] == 16'h0};
    e.t = cyc;
    @(posedge clk);
    if (l0) m[a0] = d0;
    #1;
    cmd_valid = 0;
    ld_en = l1;
    ld_addr = AW'(a1);
    ld_data = d1;
    @(posedge clk);
    if (l1) m[a1] = d1;
    if (op[3]) begin
      m[pd] = r[15:0];
      m[pd + 1] = r[31:16];
    end else begin
      m[dst] = r[15:0];
    end
    q.push_back(e);
    #1 ld_en = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    cmd_valid = 0;
    cmd_op = 0;
    cmd_dst = 0;
    cmd_srca = 0;
    cmd_srcb = 0;
    ld_en = 0;
    ld_addr = 0;
    ld_data = 0;
    rd_addr = 0;
    for (int i = 0; i < NR; i++) m[i] = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    @(negedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_status", status, 0);
    chk("rst_rsp", {rsp_lo, rsp_hi}, 0);
    chk("rst_flags", rsp_flags, 0);
    chk("rst_alu", {alu_la, alu_lb, alu_op}, 0);
    for (int i = 0; i < NR; i++) chk_reg("rst_reg", i, 16'h0);

    rdy_mode = 1;
    load(1, 16'hFFFF);
    load(2, 16'h0001);
    issue(4'd0, 3, 1, 2, 0, 0, 0, 0, 0, 0);
    drain();
    chk_reg("add_r3", 3, 16'h0000);
    chk("add_status", status, 3'b101);

    load(0, 16'hFFFF);
    load(1, 16'h0001);
    load(2, 16'h0001);
    load(3, 16'h0000);
    issue(4'd8, 4, 0, 2, 0, 0, 0, 0, 0, 0);
    drain();
    chk_reg("add2_r4", 4, 16'h0000);
    chk_reg("add2_r5", 5, 16'h0002);
    load(4, 16'h5555);
    load(5, 16'h5555);
    issue(4'd8, 5, 1, 2, 0, 0, 0, 0, 0, 0);
    drain();
    chk_reg("odd_r4", 4, 16'h0000);
    chk_reg("odd_r5", 5, 16'h0002);

    rdy_mode = 2;
    issue(4'd1, 6, 1, 2, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cmd_valid = 1;
      cmd_op = 4'd4;
      cmd_dst = 3'd7;
      cmd_srca = 3'd1;
      cmd_srcb = 3'd6;
      #1;
      chk("hold_cmd_ready", cmd_ready, 0);
      chk("hold_rsp_valid", rsp_valid, 1);
    end
    rdy_mode = 1;
    issue(4'd4, 7, 1, 6, 0, 0, 0, 0, 0, 0);
    drain();

    load(6, 16'h0010);
    issue(4'd7, 6, 6, 6, 0, 0, 0, 1, 6, 16'h1234);
    drain();
    chk_reg("wb_wins_r6", 6, 16'h0011);
    issue(4'd7, 6, 6, 6, 0, 0, 0, 1, 7, 16'hBEEF);
    drain();
    chk_reg("par_r6", 6, 16'h0012);
    chk_reg("par_r7", 7, 16'hBEEF);
    issue(4'd0, 0, 1, 2, 1, 1, 16'h0100, 0, 0, 0);
    drain();
    chk_reg("preload_r0", 0, 16'h0002);

    load(1, 16'h0005);
    wait_idle();
    cmd_valid = 1;
    cmd_op = 4'd7;
    cmd_dst = 3'd1;
    cmd_srca = 3'd1;
    cmd_srcb = 3'd1;
    @(posedge clk);
    #1 cmd_valid = 0;
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < NR; i++) m[i] = 0;
    @(negedge clk);
    #1;
    chk("rstx_rsp_valid", rsp_valid, 0);
    chk("rstx_cmd_ready", cmd_ready, 1);
    chk("rstx_status", status, 0);
    for (int i = 0; i < NR; i++) chk_reg("rstx_reg", i, 16'h0);

    rdy_mode = 0;
    for (int i = 0; i < NR; i++) load(i, 16'($urandom));
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 3) == 0)
        load($urandom_range(0, NR - 1), 16'($urandom));
      issue(4'($urandom_range(0, 15)), $urandom_range(0, NR - 1),
            $urandom_range(0, NR - 1), $urandom_range(0, NR - 1),
            1'($urandom_range(0, 1)), $urandom_range(0, NR - 1),
            16'($urandom),
            1'($urandom_range(0, 1)), $urandom_range(0, NR - 1),
            16'($urandom));
    end
    drain();
    for (int i = 0; i < NR; i++) chk_reg("final_reg", i, m[i]);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
